// File: rtl/exec_pkg.sv
// Shared definitions for the parametrised execution stage: opcodes, flag bit
// positions and the multiplier sequencing states.
package exec_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_ADC  = 5'b00001;
    localparam logic [4:0] OP_SUB  = 5'b00010;
    localparam logic [4:0] OP_SBB  = 5'b00011;
    localparam logic [4:0] OP_AND  = 5'b00100;
    localparam logic [4:0] OP_OR   = 5'b00101;
    localparam logic [4:0] OP_XOR  = 5'b00110;
    localparam logic [4:0] OP_NOT  = 5'b00111;
    localparam logic [4:0] OP_SLL  = 5'b01000;
    localparam logic [4:0] OP_SRL  = 5'b01001;
    localparam logic [4:0] OP_SRA  = 5'b01010;
    localparam logic [4:0] OP_INC  = 5'b01100;
    localparam logic [4:0] OP_DEC  = 5'b01101;
    localparam logic [4:0] OP_CMP  = 5'b01110;
    localparam logic [4:0] OP_MOV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_MULH = 5'b10001;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HOLD
    } exec_state_e;

endpackage

// File: rtl/exec_stage_param_mul.sv
// Iterative shift-add multiplier: one partial product per step, DATA_W steps
// after start. product_next exposes the accumulator value the next edge stores.
module exec_mul_seq
#(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  step,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic [2*DATA_W-1:0]   product,
    output logic [2*DATA_W-1:0]   product_next,
    output logic                  last,
    output logic                  done
);
    import exec_pkg::*;

    localparam int CW = $clog2(DATA_W) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W - 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(DATA_W);

    logic [2*DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0]   mplier_q, mplier_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [CW-1:0]       cnt_q, cnt_d;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (start) begin
            mcand_d  = {{DATA_W{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
        end else if (step && (cnt_q != CNT_DONE)) begin
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign product      = acc_q;
    assign product_next = acc_d;
    assign last         = (cnt_q == CNT_LAST);
    assign done         = (cnt_q == CNT_DONE);

endmodule

// File: rtl/exec_stage_param.sv
// Execution stage between decode and memory. Define EXEC_MUL_EN to build in the
// multi-cycle MUL/MULH unit and its busy handshake; otherwise they act as reserved.
module exec_stage_param
#(
    parameter int DATA_W = 8,
    parameter int RW_W   = 5,
    parameter int OP_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [DATA_W-1:0] data_in,
    input  logic [OP_W-1:0]   op_dec,
    input  logic              valid_dec,
    input  logic              mem_en_dec,
    input  logic              mem_rw_dec,
    input  logic              mem_mux_sel_dec,
    input  logic [RW_W-1:0]   RW_dec,
    input  logic              stall_in,
    output logic [DATA_W-1:0] ans_ex,
    output logic [3:0]        flag_ex,
    output logic [DATA_W-1:0] data_out,
    output logic [DATA_W-1:0] B_Bypass,
    output logic              mem_en_ex,
    output logic              mem_rw_ex,
    output logic              mem_mux_sel_ex,
    output logic [RW_W-1:0]   RW_ex,
    output logic              valid_ex,
    output logic              busy_ex
);
    import exec_pkg::*;

    localparam int MSB  = DATA_W - 1;
    localparam int SH_W = $clog2(DATA_W);
    localparam logic [DATA_W:0] EXT_ONE = {{DATA_W{1'b0}}, 1'b1};

    logic [DATA_W-1:0] ans_q, ans_d, data_out_q, data_out_d, b_bypass_q, b_bypass_d;
    logic [3:0]        flag_q, flag_d;
    logic              mem_en_q, mem_en_d, mem_rw_q, mem_rw_d, mem_mux_q, mem_mux_d;
    logic [RW_W-1:0]   rw_q, rw_d;
    logic              valid_q, valid_d;

    logic [DATA_W:0]        alu_ext;
    logic signed [DATA_W:0] sra_ext;
    logic [SH_W-1:0]        amt;
    logic [DATA_W-1:0]      alu_res;
    logic [3:0]             alu_flags;
    logic                   alu_c, alu_v, alu_wr_ans, alu_wr_flags;
    logic                   idle, is_mul;

    assign amt = B[SH_W-1:0];

    always_comb begin
        alu_ext      = '0;
        sra_ext      = '0;
        alu_res      = A;
        alu_c        = 1'b0;
        alu_v        = 1'b0;
        alu_wr_ans   = 1'b1;
        alu_wr_flags = 1'b1;
        case (op_dec)
            OP_ADD, OP_ADC: begin
                alu_ext = {1'b0, A} + {1'b0, B} + {{DATA_W{1'b0}}, op_dec[0] & flag_q[FLAG_C]};
                alu_res = alu_ext[DATA_W-1:0];
                alu_c   = alu_ext[DATA_W];
                alu_v   = (A[MSB] == B[MSB]) && (alu_res[MSB] != A[MSB]);
            end
            OP_SUB, OP_SBB, OP_CMP: begin
                alu_ext = {1'b0, A} - {1'b0, B}
                          - {{DATA_W{1'b0}}, (op_dec == OP_SBB) & flag_q[FLAG_C]};
                alu_res = alu_ext[DATA_W-1:0];
                alu_c   = alu_ext[DATA_W];
                alu_v   = (A[MSB] != B[MSB]) && (alu_res[MSB] != A[MSB]);
                alu_wr_ans = (op_dec != OP_CMP);
            end
            OP_AND: alu_res = A & B;
            OP_OR:  alu_res = A | B;
            OP_XOR: alu_res = A ^ B;
            OP_NOT: alu_res = ~A;
            // An extra guard bit catches the last bit shifted out; zero amount leaves it 0.
            OP_SLL: begin
                alu_ext = {1'b0, A} << amt;
                alu_res = alu_ext[DATA_W-1:0];
                alu_c   = alu_ext[DATA_W];
            end
            OP_SRL: begin
                alu_ext = {A, 1'b0} >> amt;
                alu_res = alu_ext[DATA_W:1];
                alu_c   = alu_ext[0];
            end
            OP_SRA: begin
                sra_ext = $signed({A, 1'b0}) >>> amt;
                alu_res = sra_ext[DATA_W:1];
                alu_c   = sra_ext[0];
            end
            OP_INC: begin
                alu_ext = {1'b0, A} + EXT_ONE;
                alu_res = alu_ext[DATA_W-1:0];
                alu_c   = alu_ext[DATA_W];
                alu_v   = !A[MSB] && alu_res[MSB];
            end
            OP_DEC: begin
                alu_ext = {1'b0, A} - EXT_ONE;
                alu_res = alu_ext[DATA_W-1:0];
                alu_c   = alu_ext[DATA_W];
                alu_v   = A[MSB] && !alu_res[MSB];
            end
            OP_MOV: alu_res = B;
            default: alu_wr_flags = 1'b0;
        endcase
        alu_flags         = '0;
        alu_flags[FLAG_V] = alu_v;
        alu_flags[FLAG_N] = alu_res[MSB];
        alu_flags[FLAG_C] = alu_c;
        alu_flags[FLAG_Z] = (alu_res == '0);
    end

`ifdef EXEC_MUL_EN
    exec_state_e         state_q, state_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   lat_data_q, lat_data_d, lat_b_q, lat_b_d;
    logic [RW_W-1:0]     lat_rw_q, lat_rw_d;
    logic                lat_mem_en_q, lat_mem_en_d, lat_mem_rw_q, lat_mem_rw_d;
    logic                lat_mux_q, lat_mux_d, lat_hi_q, lat_hi_d;
    logic                mul_start, mul_step, mul_last, mul_done;
    logic [2*DATA_W-1:0] mul_prod, mul_prod_next, mul_src;
    logic [DATA_W-1:0]   mul_word;

    exec_mul_seq #(.DATA_W(DATA_W)) u_mul (
        .clk          (clk),
        .reset        (reset),
        .start        (mul_start),
        .step         (mul_step),
        .a            (A),
        .b            (B),
        .product      (mul_prod),
        .product_next (mul_prod_next),
        .last         (mul_last),
        .done         (mul_done)
    );

    assign idle     = (state_q == ST_IDLE);
    assign is_mul   = (op_dec == OP_MUL) || (op_dec == OP_MULH);
    assign mul_step = (state_q == ST_RUN);
    // On the final iteration edge the product is still in flight; in HOLD it is stored.
    assign mul_src  = (state_q == ST_RUN) ? mul_prod_next : mul_prod;
    assign mul_word = lat_hi_q ? mul_src[2*DATA_W-1:DATA_W] : mul_src[DATA_W-1:0];
    assign busy_ex  = busy_q;
`else
    assign idle    = 1'b1;
    assign is_mul  = 1'b0;
    assign busy_ex = 1'b0;
`endif

    always_comb begin
        ans_d      = ans_q;
        flag_d     = flag_q;
        data_out_d = data_out_q;
        b_bypass_d = b_bypass_q;
        mem_en_d   = mem_en_q;
        mem_rw_d   = mem_rw_q;
        mem_mux_d  = mem_mux_q;
        rw_d       = rw_q;
        valid_d    = valid_q;
`ifdef EXEC_MUL_EN
        state_d      = state_q;
        busy_d       = busy_q;
        lat_data_d   = lat_data_q;
        lat_b_d      = lat_b_q;
        lat_rw_d     = lat_rw_q;
        lat_mem_en_d = lat_mem_en_q;
        lat_mem_rw_d = lat_mem_rw_q;
        lat_mux_d    = lat_mux_q;
        lat_hi_d     = lat_hi_q;
        mul_start    = 1'b0;
`endif
        if (idle && !stall_in) begin
            if (valid_dec && !is_mul) begin
                if (alu_wr_ans)   ans_d  = alu_res;
                if (alu_wr_flags) flag_d = alu_flags;
                data_out_d = data_in;
                b_bypass_d = B;
                mem_en_d   = mem_en_dec;
                mem_rw_d   = mem_rw_dec;
                mem_mux_d  = mem_mux_sel_dec;
                rw_d       = RW_dec;
                valid_d    = 1'b1;
            end else if (!valid_dec) begin
                valid_d  = 1'b0;
                mem_en_d = 1'b0;
                mem_rw_d = 1'b0;
            end
        end
`ifdef EXEC_MUL_EN
        if (idle && !stall_in && valid_dec && is_mul) begin
            mul_start    = 1'b1;
            state_d      = ST_RUN;
            busy_d       = 1'b1;
            valid_d      = 1'b0;
            mem_en_d     = 1'b0;
            mem_rw_d     = 1'b0;
            lat_data_d   = data_in;
            lat_b_d      = B;
            lat_rw_d     = RW_dec;
            lat_mem_en_d = mem_en_dec;
            lat_mem_rw_d = mem_rw_dec;
            lat_mux_d    = mem_mux_sel_dec;
            lat_hi_d     = (op_dec == OP_MULH);
        end
        if (((state_q == ST_RUN) && mul_last && !stall_in) ||
            ((state_q == ST_HOLD) && mul_done && !stall_in)) begin
            ans_d          = mul_word;
            flag_d         = '0;
            flag_d[FLAG_N] = mul_word[MSB];
            flag_d[FLAG_C] = |mul_src[2*DATA_W-1:DATA_W];
            flag_d[FLAG_Z] = (mul_word == '0);
            data_out_d     = lat_data_q;
            b_bypass_d     = lat_b_q;
            mem_en_d       = lat_mem_en_q;
            mem_rw_d       = lat_mem_rw_q;
            mem_mux_d      = lat_mux_q;
            rw_d           = lat_rw_q;
            valid_d        = 1'b1;
            busy_d         = 1'b0;
            state_d        = ST_IDLE;
        end else if ((state_q == ST_RUN) && mul_last) begin
            state_d = ST_HOLD;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ans_q      <= '0;
            flag_q     <= '0;
            data_out_q <= '0;
            b_bypass_q <= '0;
            mem_en_q   <= 1'b0;
            mem_rw_q   <= 1'b0;
            mem_mux_q  <= 1'b0;
            rw_q       <= '0;
            valid_q    <= 1'b0;
`ifdef EXEC_MUL_EN
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            lat_data_q   <= '0;
            lat_b_q      <= '0;
            lat_rw_q     <= '0;
            lat_mem_en_q <= 1'b0;
            lat_mem_rw_q <= 1'b0;
            lat_mux_q    <= 1'b0;
            lat_hi_q     <= 1'b0;
`endif
        end else begin
            ans_q      <= ans_d;
            flag_q     <= flag_d;
            data_out_q <= data_out_d;
            b_bypass_q <= b_bypass_d;
            mem_en_q   <= mem_en_d;
            mem_rw_q   <= mem_rw_d;
            mem_mux_q  <= mem_mux_d;
            rw_q       <= rw_d;
            valid_q    <= valid_d;
`ifdef EXEC_MUL_EN
            state_q      <= state_d;
            busy_q       <= busy_d;
            lat_data_q   <= lat_data_d;
            lat_b_q      <= lat_b_d;
            lat_rw_q     <= lat_rw_d;
            lat_mem_en_q <= lat_mem_en_d;
            lat_mem_rw_q <= lat_mem_rw_d;
            lat_mux_q    <= lat_mux_d;
            lat_hi_q     <= lat_hi_d;
`endif
        end
    end

    assign ans_ex         = ans_q;
    assign flag_ex        = flag_q;
    assign data_out       = data_out_q;
    assign B_Bypass       = b_bypass_q;
    assign mem_en_ex      = mem_en_q;
    assign mem_rw_ex      = mem_rw_q;
    assign mem_mux_sel_ex = mem_mux_q;
    assign RW_ex          = rw_q;
    assign valid_ex       = valid_q;

endmodule

// File: tb/tb_exec_stage_param.sv
// Directed bench for exec_stage_param (DATA_W=8); expectations follow the
// EXEC_MUL_EN build setting so both configurations are covered.
module tb_exec_stage_param;
    import exec_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] a_in = '0, b_in = '0, data_in = '0;
    logic [4:0] op_dec = '0, rw_dec = '0;
    logic       valid_dec = 1'b0, mem_en_dec = 1'b0, mem_rw_dec = 1'b0, mem_mux_sel_dec = 1'b0;
    logic       stall_in = 1'b0;
    logic [7:0] ans_ex, data_out, b_bypass;
    logic [3:0] flag_ex;
    logic       mem_en_ex, mem_rw_ex, mem_mux_sel_ex, valid_ex, busy_ex;
    logic [4:0] rw_ex;

    int vectors = 0;
    int miscompares = 0;

    exec_stage_param #(.DATA_W(8), .RW_W(5), .OP_W(5)) dut (
        .clk             (clk),
        .reset           (reset),
        .A               (a_in),
        .B               (b_in),
        .data_in         (data_in),
        .op_dec          (op_dec),
        .valid_dec       (valid_dec),
        .mem_en_dec      (mem_en_dec),
        .mem_rw_dec      (mem_rw_dec),
        .mem_mux_sel_dec (mem_mux_sel_dec),
        .RW_dec          (rw_dec),
        .stall_in        (stall_in),
        .ans_ex          (ans_ex),
        .flag_ex         (flag_ex),
        .data_out        (data_out),
        .B_Bypass        (b_bypass),
        .mem_en_ex       (mem_en_ex),
        .mem_rw_ex       (mem_rw_ex),
        .mem_mux_sel_ex  (mem_mux_sel_ex),
        .RW_ex           (rw_ex),
        .valid_ex        (valid_ex),
        .busy_ex         (busy_ex)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input logic vld, input logic [4:0] rw, input logic [2:0] mem,
                                 input logic [7:0] din);
        op_dec    = op;
        a_in      = a;
        b_in      = b;
        valid_dec = vld;
        rw_dec    = rw;
        {mem_en_dec, mem_rw_dec, mem_mux_sel_dec} = mem;
        data_in   = din;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic aluStep(input string tag, input logic [4:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] exp_ans, input logic [3:0] exp_flags);
        applyStimulus(op, a, b, 1'b1, 5'h07, 3'b000, 8'h00);
        stepClock();
        checkOutput({tag, "_ans"}, ans_ex, exp_ans);
        checkOutput({tag, "_flags"}, flag_ex, exp_flags);
        checkOutput({tag, "_valid"}, valid_ex, 1'b1);
    endtask

    task automatic doMul(input string tag, input logic [4:0] op, input logic [7:0] exp_ans,
                         input logic [3:0] exp_flags);
`ifdef EXEC_MUL_EN
        int busy_cycles;
`endif
        applyStimulus(op, 8'hC0, 8'h03, 1'b1, 5'h0A, 3'b111, 8'h77);
        stepClock();
`ifdef EXEC_MUL_EN
        checkOutput({tag, "_busy_e0"}, busy_ex, 1'b1);
        checkOutput({tag, "_valid_e0"}, valid_ex, 1'b0);
        busy_cycles = 1;
        applyStimulus(OP_ADD, 8'hFF, 8'hFF, 1'b0, 5'h1F, 3'b000, 8'h00);
        for (int i = 0; i < 20 && busy_ex; i++) begin
            stepClock();
            if (busy_ex) busy_cycles++;
        end
        checkOutput({tag, "_busy_len"}, busy_cycles, 8);
`endif
        checkOutput({tag, "_busy_end"}, busy_ex, 1'b0);
        checkOutput({tag, "_ans"}, ans_ex, exp_ans);
        checkOutput({tag, "_flags"}, flag_ex, exp_flags);
        checkOutput({tag, "_rw"}, rw_ex, 5'h0A);
        checkOutput({tag, "_mem"}, {mem_en_ex, mem_rw_ex, mem_mux_sel_ex}, 3'b111);
        checkOutput({tag, "_valid"}, valid_ex, 1'b1);
        checkOutput({tag, "_data"}, {data_out, b_bypass}, 16'h7703);
    endtask

    initial begin
        $display("[TB] start");
        stepClock();
        stepClock();
        checkOutput("rst_ans", ans_ex, 8'h00);
        checkOutput("rst_flags", flag_ex, 4'h0);
        checkOutput("rst_ctrl", {valid_ex, busy_ex, mem_en_ex, mem_rw_ex, mem_mux_sel_ex}, 5'b0);
        checkOutput("rst_data", {data_out, b_bypass, 3'b000, rw_ex}, 24'h0);
        reset = 1'b1;
        applyStimulus(OP_ADD, 8'h12, 8'h34, 1'b0, 5'h01, 3'b111, 8'h00);
        stepClock();
        checkOutput("idle_bubble", {valid_ex, mem_en_ex, ans_ex}, 10'h000);

        applyStimulus(OP_ADD, 8'h40, 8'hC0, 1'b1, 5'h03, 3'b101, 8'h55);
        stepClock();
        checkOutput("add_ans", ans_ex, 8'h00);
        checkOutput("add_flags", flag_ex, 4'b0011);
        checkOutput("add_valid", valid_ex, 1'b1);
        checkOutput("add_rw", rw_ex, 5'h03);
        checkOutput("add_mem", {mem_en_ex, mem_rw_ex, mem_mux_sel_ex}, 3'b101);
        checkOutput("add_data", {data_out, b_bypass}, 16'h55C0);

        applyStimulus(OP_SUB, 8'h40, 8'hC0, 1'b1, 5'h04, 3'b000, 8'h00);
        stepClock();
        checkOutput("sub_ans", ans_ex, 8'h80);
        checkOutput("sub_flags", flag_ex, 4'b1110);

        applyStimulus(OP_ADC, 8'h01, 8'h01, 1'b1, 5'h05, 3'b111, 8'h11);
        stepClock();
        checkOutput("adc_ans", ans_ex, 8'h03);
        checkOutput("adc_flags", flag_ex, 4'b0000);
        checkOutput("adc_mem", {mem_en_ex, mem_rw_ex, mem_mux_sel_ex}, 3'b111);

        applyStimulus(OP_ADD, 8'hFF, 8'hFF, 1'b0, 5'h1F, 3'b111, 8'hAA);
        stepClock();
        checkOutput("bub_valid", valid_ex, 1'b0);
        checkOutput("bub_mem", {mem_en_ex, mem_rw_ex, mem_mux_sel_ex}, 3'b001);
        checkOutput("bub_hold", {ans_ex, data_out, 3'b000, rw_ex}, 24'h031105);

        applyStimulus(OP_ADD, 8'h10, 8'h20, 1'b1, 5'h06, 3'b000, 8'h22);
        stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            stepClock();
            checkOutput("stall_frozen", {ans_ex, valid_ex, 3'b000, rw_ex}, {8'h03, 1'b0, 8'h05});
        end
        stall_in = 1'b0;
        stepClock();
        checkOutput("stall_release_ans", ans_ex, 8'h30);
        checkOutput("stall_release_ctl", {valid_ex, 3'b000, rw_ex}, {1'b1, 8'h06});

        aluStep("xor", OP_XOR, 8'hF0, 8'hFF, 8'h0F, 4'b0000);
        aluStep("mov", OP_MOV, 8'h11, 8'h00, 8'h00, 4'b0001);
        aluStep("sra", OP_SRA, 8'h81, 8'h01, 8'hC0, 4'b0110);
        aluStep("rsvd", 5'b11111, 8'h5A, 8'h00, 8'h5A, 4'b0110);
        aluStep("cmp", OP_CMP, 8'h05, 8'h05, 8'h5A, 4'b0001);
        aluStep("sll", OP_SLL, 8'h81, 8'h01, 8'h02, 4'b0010);
        aluStep("srl0", OP_SRL, 8'h81, 8'h00, 8'h81, 4'b0100);
        aluStep("inc", OP_INC, 8'h7F, 8'h00, 8'h80, 4'b1100);
        aluStep("dec", OP_DEC, 8'h00, 8'h00, 8'hFF, 4'b0110);

`ifdef EXEC_MUL_EN
        doMul("mul", OP_MUL, 8'h40, 4'b0010);
        doMul("mulh", OP_MULH, 8'h02, 4'b0010);

        applyStimulus(OP_MUL, 8'hC0, 8'h03, 1'b1, 5'h0B, 3'b101, 8'h66);
        stepClock();
        checkOutput("smul_busy_e0", busy_ex, 1'b1);
        applyStimulus(OP_ADD, 8'h01, 8'h01, 1'b1, 5'h0C, 3'b000, 8'h00);
        repeat (4) stepClock();
        stall_in = 1'b1;
        repeat (6) stepClock();
        checkOutput("smul_parked", {busy_ex, valid_ex, ans_ex}, {1'b1, 1'b0, 8'h02});
        stall_in = 1'b0;
        stepClock();
        checkOutput("smul_write", {busy_ex, valid_ex, ans_ex}, {1'b1 ^ 1'b1, 1'b1, 8'h40});
        checkOutput("smul_rw", rw_ex, 5'h0B);
        checkOutput("smul_flags", flag_ex, 4'b0010);
        stepClock();
        checkOutput("held_add_ans", ans_ex, 8'h02);
        checkOutput("held_add_rw", rw_ex, 5'h0C);
`else
        doMul("mul", OP_MUL, 8'hC0, 4'b0110);
        doMul("mulh", OP_MULH, 8'hC0, 4'b0110);
`endif

        applyStimulus(OP_MUL, 8'hC0, 8'h03, 1'b1, 5'h0D, 3'b111, 8'h44);
        stepClock();
        applyStimulus(OP_ADD, 8'h00, 8'h00, 1'b0, 5'h00, 3'b000, 8'h00);
        repeat (4) stepClock();
        reset = 1'b0;
        #2;
        checkOutput("midrst_ans", ans_ex, 8'h00);
        checkOutput("midrst_ctl", {busy_ex, valid_ex, mem_en_ex, flag_ex}, 7'b0);
        checkOutput("midrst_data", {data_out, 3'b000, rw_ex}, 16'h0000);
        #2;
        reset = 1'b1;
        applyStimulus(OP_ADD, 8'h02, 8'h03, 1'b1, 5'h01, 3'b000, 8'h00);
        stepClock();
        checkOutput("post_rst_ans", ans_ex, 8'h05);
        checkOutput("post_rst_ctl", {busy_ex, valid_ex, flag_ex}, {1'b0, 1'b1, 4'b0000});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/exec_stage_param.md
# exec_stage_param

Parametrised successor to the 8-bit execution stage, sitting between decode and memory in the pipeline. It performs single-cycle ALU operations of configurable width and registers their results, flags and memory/write-back control to the memory stage. An optional multi-cycle shift-add multiplier stalls decode through a busy handshake. It also honours a downstream stall.

## Interface
- `DATA_W`, 8: operand/result width (≥4, power of two)
- `RW_W`, 5: destination register address width
- `OP_W`, 5: opcode width (fixed encoding below needs 5)

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `A`, `B`  in  DATA_W  operands
- `data_in`  in  DATA_W  store data from decode
- `op_dec`  in  OP_W  opcode
- `valid_dec`  in  1  decode presents a real instruction
- `mem_en_dec`, `mem_rw_dec`, `mem_mux_sel_dec`  in  1  memory control
- `RW_dec`  in  RW_W  destination register
- `stall_in`  in  1  memory stage cannot accept
- `ans_ex`  out  DATA_W  result
- `flag_ex`  out  4  {V,N,C,Z} = [3:0]
- `data_out`, `B_Bypass`  out  DATA_W  registered `data_in`, `B`
- `mem_en_ex`, `mem_rw_ex`, `mem_mux_sel_ex`  out  1  registered memory control
- `RW_ex`  out  RW_W  registered destination
- `valid_ex`  out  1  outputs carry a real instruction
- `busy_ex`  out  1  decode must hold inputs

## Operation
- Opcodes:
  - `00000` ADD, `00001` ADC (+C), `00010` SUB, `00011` SBB (−C)
  - `00100` AND, `00101` OR, `00110` XOR, `00111` NOT A
  - `01000` SLL, `01001` SRL, `01010` SRA (amount = B[log2(DATA_W)-1:0])
  - `01100` INC A, `01101` DEC A, `01110` CMP (A−B, ans_ex holds), `01111` MOV B
  - `10000` MUL (low half), `10001` MULH (high half)
  - all other codes are reserved: ans = A, flags held
- Flags:
  - Z = (ans == 0)
  - N = ans MSB
  - C = carry out for add/inc; borrow for sub/sbb/dec/cmp; last bit shifted out for shifts, 0 if amount is 0; C = |high half for MUL/MULH
  - V = signed overflow for add/sub/inc/dec/cmp; 0 otherwise
  - ADC/SBB use the registered C in `flag_ex`
- An instruction is accepted when `valid_dec`=1, `busy_ex`=0 and `stall_in`=0.
- Bubble (`valid_dec`=0, no stall): `valid_ex`, `mem_en_ex` and `mem_rw_ex` go to 0; all other outputs hold.
- FSM (present only with the multiplier): IDLE → RUN on accepting MUL/MULH. RUN counts DATA_W iterations, then writes outputs → IDLE, or → HOLD if `stall_in`=1. HOLD → IDLE, writing outputs, once `stall_in`=0.
- While in RUN or HOLD, decode inputs are ignored. The operands, `RW_dec` and control latched at accept are used.

## Timing
- Reset: every output is 0 and state is IDLE. Reset asserted mid-multiply aborts it with no output write.
- Single-cycle ops: outputs update on the accept edge (latency 1).
- MUL/MULH accepted at edge E0: `busy_ex`=1 and `valid_ex`=0 from E0. One iteration runs per edge E1..E(DATA_W). At E(DATA_W) the outputs are written, `valid_ex`=1 and `busy_ex`=0.
- `busy_ex` is registered and is high for exactly DATA_W cycles when unstalled.
- `stall_in`=1: all output registers hold, including `valid_ex`, and nothing is accepted. A running multiply keeps iterating and parks in HOLD.
- The instruction held by decode during busy is accepted on the first edge with `busy_ex`=0.

## Configuration
- `EXEC_MUL_EN` defined: multiplier, FSM and `busy_ex` logic are compiled in.
- `EXEC_MUL_EN` undefined: MUL/MULH decode as reserved (ans = A, flags held) and complete in one cycle. `busy_ex` is tied to 0.

## Structure
- Package `exec_pkg` holds:
  - opcode localparams
  - flag bit indices
  - FSM state enum
- Sub-module `exec_mul_seq`: shift-add multiplier with start/done, DATA_W-wide, 2·DATA_W product.

## Test plan
- Reset held low, then released: all outputs 0. With DATA_W=8, ADD A=0x40, B=0xC0 → `ans_ex`=0x00, Z=1 C=1 N=0 V=0, one cycle after accept.
- SUB A=0x40, B=0xC0 → 0x80, C=1 N=1 V=1 Z=0. Then ADC A=0x01, B=0x01 → 0x03.
- MUL A=0xC0, B=0x03 with `RW_dec`=0x0A, mem bits=1 → `busy_ex` high for 8 cycles, then `ans_ex`=0x40, C=1, `RW_ex`=0x0A, mem outputs=1, `valid_ex`=1. MULH on the same operands → 0x02.
- `stall_in`=1 for 3 cycles during ADD → outputs frozen. MUL completing during stall stays busy until `stall_in` drops, then writes.
- `reset` pulsed low at iteration 4 of MUL → outputs 0, `busy_ex`=0, next ADD executes normally.
- SRA A=0x81, B=0x01 → 0xC0, C=1. Reserved op `11111` → ans=A, flags unchanged. Build without `EXEC_MUL_EN`: MUL → ans=A, `busy_ex` stays 0.
